// File: rtl/ysyx_bus_arb.sv
// ---------------------------------------------------------------------------
// ysyx_bus_arb
//   Two-master / one-slave bus arbiter. The instruction fetch unit (read-only)
//   and the load/store unit (read/write) share one memory port. A single
//   transaction is outstanding at a time: the winner's request is latched,
//   presented to the slave until granted, and the response is routed back to
//   the owner. A watchdog forces an error response if the slave stays silent.
//
//   Optional feature (macro YSYX_ARB_RR_EN):
//     defined   -> round-robin between IFU and LSU when both request.
//     undefined -> fixed priority, LSU wins over IFU.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   ifu_araddr/ifu_arvalid   IFU read request (held until ifu_rvalid)
//   ifu_rdata/ifu_rvalid     IFU response, one-cycle strobe
//   ifu_err                  IFU response is a watchdog timeout
//   lsu_addr/we/wdata/wstrb  LSU request fields
//   lsu_valid                LSU request (held until lsu_rvalid)
//   lsu_rdata/lsu_rvalid     LSU response (rdata is 0 for writes)
//   lsu_err                  LSU response is a watchdog timeout
//   m_req/we/addr/wdata/wstrb  slave request, stable until m_gnt
//   m_gnt                    slave accepted the request
//   m_rvalid/m_rdata         slave response
// ---------------------------------------------------------------------------
module ysyx_bus_arb #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TMO_CYC = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     ifu_araddr,
   input  logic                  ifu_arvalid,
   output logic [DATA_W-1:0]     ifu_rdata,
   output logic                  ifu_rvalid,
   input  logic [ADDR_W-1:0]     lsu_addr,
   input  logic                  lsu_we,
   input  logic [DATA_W-1:0]     lsu_wdata,
   input  logic [DATA_W/8-1:0]   lsu_wstrb,
   input  logic                  lsu_valid,
   output logic [DATA_W-1:0]     lsu_rdata,
   output logic                  lsu_rvalid,
   output logic                  lsu_err,
   output logic                  ifu_err,
   output logic                  m_req,
   output logic                  m_we,
   output logic [ADDR_W-1:0]     m_addr,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [DATA_W/8-1:0]   m_wstrb,
   input  logic                  m_gnt,
   input  logic                  m_rvalid,
   input  logic [DATA_W-1:0]     m_rdata
);

   localparam int CNT_W = $clog2(TMO_CYC + 1);
   localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TMO_CYC);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU} owner_t;

   state_t           r_state;
   owner_t           r_owner;
   logic [CNT_W-1:0] r_cnt;
   // One-cycle masks: the master just served may still hold its request in
   // the first IDLE cycle after its response; it must not be re-granted.
   logic             r_mask_ifu;
   logic             r_mask_lsu;

   logic w_ifu_req;
   logic w_lsu_req;
   logic w_pick_lsu;

   assign w_ifu_req = ifu_arvalid & ~r_mask_ifu;
   assign w_lsu_req = lsu_valid   & ~r_mask_lsu;

`ifdef YSYX_ARB_RR_EN
   // 1 = LSU was granted most recently, 0 = IFU (reset value).
   logic r_last_lsu;
   assign w_pick_lsu = w_lsu_req & (~w_ifu_req | ~r_last_lsu);
`else
   assign w_pick_lsu = w_lsu_req;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_owner    <= OWN_NONE;
         r_cnt      <= '0;
         r_mask_ifu <= 1'b0;
         r_mask_lsu <= 1'b0;
`ifdef YSYX_ARB_RR_EN
         r_last_lsu <= 1'b0;
`endif
         m_req      <= 1'b0;
         m_we       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_wstrb    <= '0;
         ifu_rvalid <= 1'b0;
         lsu_rvalid <= 1'b0;
         ifu_err    <= 1'b0;
         lsu_err    <= 1'b0;
         ifu_rdata  <= '0;
         lsu_rdata  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_mask_ifu <= 1'b0;
               r_mask_lsu <= 1'b0;
               if (w_ifu_req | w_lsu_req) begin
                  r_state <= S_REQ;
                  m_req   <= 1'b1;
                  if (w_pick_lsu) begin
                     r_owner <= OWN_LSU;
                     m_we    <= lsu_we;
                     m_addr  <= lsu_addr;
                     m_wdata <= lsu_wdata;
                     m_wstrb <= lsu_wstrb;
                  end else begin
                     // IFU is read-only: never drive a write toward the slave.
                     r_owner <= OWN_IFU;
                     m_we    <= 1'b0;
                     m_addr  <= ifu_araddr;
                     m_wdata <= '0;
                     m_wstrb <= '0;
                  end
`ifdef YSYX_ARB_RR_EN
                  r_last_lsu <= w_pick_lsu;
`endif
               end
            end

            S_REQ: begin
               if (m_gnt) begin
                  m_req   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_WAIT;
               end
            end

            S_WAIT: begin
               // A real response wins over a timeout landing in the same cycle.
               if (m_rvalid) begin
                  r_state <= S_RSP;
                  if (r_owner == OWN_LSU) begin
                     lsu_rvalid <= 1'b1;
                     lsu_err    <= 1'b0;
                     lsu_rdata  <= m_we ? '0 : m_rdata;
                  end else begin
                     ifu_rvalid <= 1'b1;
                     ifu_err    <= 1'b0;
                     ifu_rdata  <= m_rdata;
                  end
               end else if (r_cnt == TMO_VAL) begin
                  r_state <= S_RSP;
                  if (r_owner == OWN_LSU) begin
                     lsu_rvalid <= 1'b1;
                     lsu_err    <= 1'b1;
                     lsu_rdata  <= '0;
                  end else begin
                     ifu_rvalid <= 1'b1;
                     ifu_err    <= 1'b1;
                     ifu_rdata  <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            S_RSP: begin
               ifu_rvalid <= 1'b0;
               lsu_rvalid <= 1'b0;
               ifu_err    <= 1'b0;
               lsu_err    <= 1'b0;
               r_mask_ifu <= (r_owner == OWN_IFU);
               r_mask_lsu <= (r_owner == OWN_LSU);
               r_owner    <= OWN_NONE;
               r_state    <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_bus_arb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_bus_arb
//   Self-checking bench for ysyx_bus_arb (TMO_CYC = 4). The bench plays both
//   masters and the slave; a transaction-level model tracks pending requests,
//   the served-master mask, the last-granted master and the expected response
//   cycle, and every observable output is compared against it.
// ---------------------------------------------------------------------------
module tb_ysyx_bus_arb;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 4;
`ifdef YSYX_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] ifu_araddr = '0;
   logic          ifu_arvalid = 1'b0;
   logic [DW-1:0] ifu_rdata;
   logic          ifu_rvalid;
   logic [AW-1:0] lsu_addr = '0;
   logic          lsu_we = 1'b0;
   logic [DW-1:0] lsu_wdata = '0;
   logic [SW-1:0] lsu_wstrb = '0;
   logic          lsu_valid = 1'b0;
   logic [DW-1:0] lsu_rdata;
   logic          lsu_rvalid;
   logic          lsu_err;
   logic          ifu_err;
   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [SW-1:0] m_wstrb;
   logic          m_gnt = 1'b0;
   logic          m_rvalid = 1'b0;
   logic [DW-1:0] m_rdata = '0;

   ysyx_bus_arb #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) u_dut (
      .clk(clk), .rst(rst),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
      .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
      .lsu_addr(lsu_addr), .lsu_we(lsu_we), .lsu_wdata(lsu_wdata),
      .lsu_wstrb(lsu_wstrb), .lsu_valid(lsu_valid),
      .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
      .lsu_err(lsu_err), .ifu_err(ifu_err),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_wstrb(m_wstrb), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   bit ifu_pend, lsu_pend;    // master currently asserting a request
   bit mask_ifu, mask_lsu;    // master just served (first IDLE cycle after RSP)
   bit held_ifu, held_lsu;    // served master keeps request one extra cycle
   bit last_lsu;              // LSU was granted most recently

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req_ifu(input logic [AW-1:0] a);
      ifu_araddr  = a;
      ifu_arvalid = 1'b1;
      ifu_pend    = 1'b1;
   endtask

   task automatic req_lsu(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
      lsu_we    = w;
      lsu_addr  = a;
      lsu_wdata = d;
      lsu_wstrb = s;
      lsu_valid = 1'b1;
      lsu_pend  = 1'b1;
   endtask

   task automatic check_bus(input string tag, input logic [AW-1:0] a, input logic we,
                            input logic [DW-1:0] d, input logic [SW-1:0] s);
      check({tag, "_req"},   64'(m_req),   64'(1));
      check({tag, "_addr"},  64'(m_addr),  64'(a));
      check({tag, "_we"},    64'(m_we),    64'(we));
      check({tag, "_wdata"}, 64'(m_wdata), 64'(d));
      check({tag, "_wstrb"}, 64'(m_wstrb), 64'(s));
   endtask

   // One arbitration round starting in an IDLE cycle. gnt_d: stall cycles
   // before m_gnt; k: WAIT cycle in which the slave responds (k > TMO means
   // silent); hold: served master keeps its request one cycle after rvalid;
   // late_lsu: an LSU request arrives while the transaction is in flight.
   task automatic arb_round(input int gnt_d, input int k, input bit hold,
                            input logic [DW-1:0] rdat, input bit late_lsu);
      bit            c_ifu, c_lsu, w_lsu, err;
      logic [AW-1:0] e_addr;
      logic          e_we;
      logic [DW-1:0] e_wdata, e_rd;
      logic [SW-1:0] e_wstrb;
      int            eff;
      c_ifu = ifu_pend && !mask_ifu;
      c_lsu = lsu_pend && !mask_lsu;
      if (c_ifu && c_lsu) w_lsu = RR_EN ? !last_lsu : 1'b1;
      else                w_lsu = c_lsu;
      e_addr  = w_lsu ? lsu_addr  : ifu_araddr;
      e_we    = w_lsu ? lsu_we    : 1'b0;
      e_wdata = w_lsu ? lsu_wdata : '0;
      e_wstrb = w_lsu ? lsu_wstrb : '0;

      step();
      mask_ifu = 1'b0;
      mask_lsu = 1'b0;
      if (held_ifu) begin ifu_arvalid = 1'b0; ifu_pend = 1'b0; held_ifu = 1'b0; end
      if (held_lsu) begin lsu_valid   = 1'b0; lsu_pend = 1'b0; held_lsu = 1'b0; end
      if (!c_ifu && !c_lsu) begin
         check("idle_no_req", 64'(m_req), 64'(0));
         return;
      end
      last_lsu = w_lsu;
      check_bus("arb", e_addr, e_we, e_wdata, e_wstrb);

      // Winner's inputs may change after sampling; the bus must not follow.
      if ($urandom_range(0, 1) == 1) begin
         if (w_lsu) begin lsu_addr = $urandom; lsu_wdata = $urandom; end
         else ifu_araddr = $urandom;
      end

      for (int i = 0; i < gnt_d; i++) begin
         m_rvalid = ($urandom_range(0, 3) == 0);   // ignored outside WAIT
         step();
         m_rvalid = 1'b0;
         check_bus("stall", e_addr, e_we, e_wdata, e_wstrb);
      end
      m_gnt = 1'b1;
      step();
      m_gnt = 1'b0;
      check("gnt_drop_req", 64'(m_req), 64'(0));

      if (late_lsu && !lsu_pend)
         req_lsu(1'b0, $urandom & 32'hFFFF_FFFC, $urandom, SW'($urandom));

      err = (k > TMO);
      eff = err ? TMO : k;
      for (int c = 0; c <= eff; c++) begin
         m_rvalid = (c == k);
         m_rdata  = (c == k) ? rdat : DW'($urandom);
         m_gnt    = ($urandom_range(0, 3) == 0);  // ignored outside REQ
         step();
         m_rvalid = 1'b0;
         m_gnt    = 1'b0;
         if (c < eff) begin
            check("wait_ifu_rvalid", 64'(ifu_rvalid), 64'(0));
            check("wait_lsu_rvalid", 64'(lsu_rvalid), 64'(0));
         end
      end

      e_rd = (err || (w_lsu && e_we)) ? '0 : rdat;
      if (w_lsu) begin
         check("lsu_rvalid", 64'(lsu_rvalid), 64'(1));
         check("lsu_err",    64'(lsu_err),    64'(err));
         check("lsu_rdata",  64'(lsu_rdata),  64'(e_rd));
         check("ifu_quiet",  64'(ifu_rvalid), 64'(0));
         mask_lsu = 1'b1;
         if (hold) held_lsu = 1'b1;
         else begin lsu_valid = 1'b0; lsu_pend = 1'b0; end
      end else begin
         check("ifu_rvalid", 64'(ifu_rvalid), 64'(1));
         check("ifu_err",    64'(ifu_err),    64'(err));
         check("ifu_rdata",  64'(ifu_rdata),  64'(e_rd));
         check("lsu_quiet",  64'(lsu_rvalid), 64'(0));
         mask_ifu = 1'b1;
         if (hold) held_ifu = 1'b1;
         else begin ifu_arvalid = 1'b0; ifu_pend = 1'b0; end
      end

      step();
      check("rsp_one_ifu", 64'(ifu_rvalid), 64'(0));
      check("rsp_one_lsu", 64'(lsu_rvalid), 64'(0));
      check("rsp_req_low", 64'(m_req),      64'(0));
   endtask

   task automatic rand_reqs();
      if (!ifu_pend && !mask_ifu && $urandom_range(0, 2) != 0)
         req_ifu($urandom & 32'hFFFF_FFFC);
      if (!lsu_pend && !mask_lsu && $urandom_range(0, 2) != 0)
         req_lsu($urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom, SW'($urandom));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ifu_pend = 0; lsu_pend = 0; mask_ifu = 0; mask_lsu = 0;
      held_ifu = 0; held_lsu = 0; last_lsu = 0;

      // Reset values
      step();
      step();
      check("rst_m_req",      64'(m_req),      64'(0));
      check("rst_m_we",       64'(m_we),       64'(0));
      check("rst_m_addr",     64'(m_addr),     64'(0));
      check("rst_m_wstrb",    64'(m_wstrb),    64'(0));
      check("rst_ifu_rvalid", 64'(ifu_rvalid), 64'(0));
      check("rst_lsu_rvalid", 64'(lsu_rvalid), 64'(0));
      check("rst_errs",       64'({ifu_err, lsu_err}), 64'(0));
      check("rst_rdata",      64'({ifu_rdata, lsu_rdata}), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      step();

      // IFU-only read
      req_ifu(32'h8000_0000);
      arb_round(0, 1, 1'b0, 32'h0000_0413, 1'b0);

      // Simultaneous IFU read and LSU write
      req_ifu(32'h8000_0004);
      req_lsu(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF);
      arb_round(1, 2, 1'b0, 32'h1234_5678, 1'b0);
      arb_round(0, 1, 1'b0, 32'h0000_0093, 1'b0);

      // Held IFU request after response, LSU arriving in flight
      req_ifu(32'h8000_0008);
      arb_round(0, 2, 1'b1, 32'h0000_0013, 1'b1);
      arb_round(0, 1, 1'b0, 32'hCAFE_F00D, 1'b0);

      // Silent slave on an LSU read, then a normal request
      req_lsu(1'b0, 32'h8000_2000, 32'h0, 4'h0);
      arb_round(0, 100, 1'b0, 32'h5555_AAAA, 1'b0);
      req_ifu(32'h8000_000C);
      req_lsu(1'b1, 32'h8000_3000, 32'h0BAD_F00D, 4'h3);
      arb_round(0, 0, 1'b0, 32'h0000_0073, 1'b0);
      arb_round(2, TMO, 1'b0, 32'h7777_0000, 1'b0);

      // Randomized traffic
      for (int r = 0; r < 120; r++) begin
         rand_reqs();
         arb_round(int'($urandom_range(0, 2)), int'($urandom_range(0, 7)),
                   $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) == 0);
      end
      // Drain anything still pending
      for (int r = 0; r < 6; r++)
         arb_round(0, 1, 1'b0, $urandom, 1'b0);

      // Reset in the middle of a transaction
      req_ifu(32'h8000_0100);
      step();
      check("mid_req_up", 64'(m_req), 64'(1));
      #2;
      rst = 1'b0;
      ifu_arvalid = 1'b0;
      #1;
      check("mid_rst_req",    64'(m_req),      64'(0));
      check("mid_rst_rvalid", 64'({ifu_rvalid, lsu_rvalid}), 64'(0));
      check("mid_rst_err",    64'({ifu_err, lsu_err}), 64'(0));
      ifu_pend = 0; lsu_pend = 0; mask_ifu = 0; mask_lsu = 0;
      held_ifu = 0; held_lsu = 0; last_lsu = 0;
      lsu_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_quiet", 64'({m_req, ifu_rvalid, lsu_rvalid}), 64'(0));
      end
      req_ifu(32'h8000_0200);
      arb_round(1, 3, 1'b0, 32'h0010_0113, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
